vram_arbiter: RTL and testbench

Two-port arbiter that shares the single word-wide read/write port of the video RAM between the 68k CPU bus interface and the blitter. It accepts one request per requester via a req/ack handshake, serialises the requests through a fixed four-state access sequence, and drives the VRAM port with registered controls. It returns read data to the winning requester. The scan-out port of the VRAM is untouched.

---
 rtl/vram_arb_pkg.sv | 27 ++
 rtl/vram_arbiter_rr_arb2.sv | 25 ++
 rtl/vram_arbiter.sv | 153 +++++++++++++++
 tb/tb_vram_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/vram_arb_pkg.sv
// Shared types and constants for the VRAM CPU/blitter arbiter.
package vram_arb_pkg;

  localparam int VRAM_AW = 14;
  localparam int VRAM_DW = 16;

  // Requester ids; also the encoding of the last_grant register.
  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_BLT = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    ACK     = 2'd3
  } arb_state_t;

  // One requester's access as seen on its port.
  typedef struct packed {
    logic               we;
    logic [VRAM_AW-1:0] addr;
    logic [VRAM_DW-1:0] wdata;
    logic               ub;
    logic               lb;
  } vram_req_t;

endpackage

// File: rtl/vram_arbiter_rr_arb2.sv
// Two-way grant: lone requester always wins; ties go to the CPU when
// FIXED_CPU_PRIO is set, otherwise to whoever was not granted last.
module rr_arb2
  import vram_arb_pkg::*;
#(
  parameter bit FIXED_CPU_PRIO = 1'b0
) (
  input  logic cpu_req,
  input  logic blt_req,
  input  logic last_grant,
  output logic gnt_vld,
  output logic gnt_id
);

  // Pure combinational pick; the caller decides when to act on it.
  always_comb begin
    gnt_vld = cpu_req | blt_req;
    gnt_id  = REQ_CPU;
    if (cpu_req && blt_req)
      gnt_id = (FIXED_CPU_PRIO || (last_grant == REQ_BLT)) ? REQ_CPU : REQ_BLT;
    else if (blt_req)
      gnt_id = REQ_BLT;
  end

endmodule

// File: rtl/vram_arbiter.sv
// Shares the VRAM read/write port between the CPU bus interface and the
// blitter. Each access runs IDLE -> ISSUE -> CAPTURE -> ACK; all VRAM
// controls, read data and acks come straight from flops.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter bit FIXED_CPU_PRIO = 1'b0
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [VRAM_AW-1:0] cpu_addr,
  input  logic [VRAM_DW-1:0] cpu_wdata,
  input  logic               cpu_ub,
  input  logic               cpu_lb,
  output logic               cpu_ack,
  input  logic               blt_req,
  input  logic               blt_we,
  input  logic [VRAM_AW-1:0] blt_addr,
  input  logic [VRAM_DW-1:0] blt_wdata,
  input  logic               blt_ub,
  input  logic               blt_lb,
  output logic               blt_ack,
  output logic [VRAM_DW-1:0] rdata,
  output logic               vram_we,
  output logic               vram_re,
  output logic [VRAM_AW-1:0] vram_addr,
  output logic [VRAM_DW-1:0] vram_din,
  output logic               vram_ub,
  output logic               vram_lb,
  input  logic [VRAM_DW-1:0] vram_dout
);

  arb_state_t         state_q, state_d;
  logic               owner_q, owner_d;
  logic               last_grant_q, last_grant_d;
  logic               rd_q, rd_d;
  logic               vram_we_q, vram_we_d;
  logic               vram_re_q, vram_re_d;
  logic [VRAM_AW-1:0] vram_addr_q, vram_addr_d;
  logic [VRAM_DW-1:0] vram_din_q, vram_din_d;
  logic               vram_ub_q, vram_ub_d;
  logic               vram_lb_q, vram_lb_d;
  logic [VRAM_DW-1:0] rdata_q, rdata_d;
  logic               cpu_ack_q, cpu_ack_d;
  logic               blt_ack_q, blt_ack_d;

  vram_req_t cpu_r, blt_r, win_r;
  logic      gnt_vld, gnt_id;

  assign cpu_r = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata, ub: cpu_ub, lb: cpu_lb};
  assign blt_r = '{we: blt_we, addr: blt_addr, wdata: blt_wdata, ub: blt_ub, lb: blt_lb};
  assign win_r = (gnt_id == REQ_BLT) ? blt_r : cpu_r;

  rr_arb2 #(
    .FIXED_CPU_PRIO(FIXED_CPU_PRIO)
  ) u_rr_arb2 (
    .cpu_req    (cpu_req),
    .blt_req    (blt_req),
    .last_grant (last_grant_q),
    .gnt_vld    (gnt_vld),
    .gnt_id     (gnt_id)
  );

  // Next-state and registered-output computation; strobes and acks are
  // single-cycle, everything else holds unless explicitly reloaded.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    rd_d         = rd_q;
    vram_we_d    = 1'b0;
    vram_re_d    = 1'b0;
    vram_addr_d  = vram_addr_q;
    vram_din_d   = vram_din_q;
    vram_ub_d    = vram_ub_q;
    vram_lb_d    = vram_lb_q;
    rdata_d      = rdata_q;
    cpu_ack_d    = 1'b0;
    blt_ack_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          owner_d      = gnt_id;
          last_grant_d = gnt_id;
          rd_d         = ~win_r.we;
          vram_we_d    = win_r.we;
          vram_re_d    = ~win_r.we;
          vram_addr_d  = win_r.addr;
          vram_din_d   = win_r.wdata;
          vram_ub_d    = win_r.ub;
          vram_lb_d    = win_r.lb;
          state_d      = ISSUE;
        end
      end
      ISSUE: state_d = CAPTURE;
      CAPTURE: begin
        // VRAM output is valid now, one cycle after the read strobe.
        if (rd_q) rdata_d = vram_dout;
        cpu_ack_d = (owner_q == REQ_CPU);
        blt_ack_d = (owner_q == REQ_BLT);
        state_d   = ACK;
      end
      ACK: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      owner_q      <= REQ_CPU;
      last_grant_q <= REQ_BLT;
      rd_q         <= 1'b0;
      vram_we_q    <= 1'b0;
      vram_re_q    <= 1'b0;
      vram_addr_q  <= '0;
      vram_din_q   <= '0;
      vram_ub_q    <= 1'b0;
      vram_lb_q    <= 1'b0;
      rdata_q      <= '0;
      cpu_ack_q    <= 1'b0;
      blt_ack_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      rd_q         <= rd_d;
      vram_we_q    <= vram_we_d;
      vram_re_q    <= vram_re_d;
      vram_addr_q  <= vram_addr_d;
      vram_din_q   <= vram_din_d;
      vram_ub_q    <= vram_ub_d;
      vram_lb_q    <= vram_lb_d;
      rdata_q      <= rdata_d;
      cpu_ack_q    <= cpu_ack_d;
      blt_ack_q    <= blt_ack_d;
    end
  end

  assign vram_we   = vram_we_q;
  assign vram_re   = vram_re_q;
  assign vram_addr = vram_addr_q;
  assign vram_din  = vram_din_q;
  assign vram_ub   = vram_ub_q;
  assign vram_lb   = vram_lb_q;
  assign rdata     = rdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign blt_ack   = blt_ack_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench: instance 0 is round-robin, instance 1 is fixed CPU
// priority; each has its own byte-enabled VRAM model.
module tb_vram_arbiter;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [13:0] addr;
    logic [15:0] wdata;
    logic        ub;
    logic        lb;
  } rq_t;

  logic        clk = 1'b0;
  logic        resetn_v [2];
  rq_t         cpu_in   [2];
  rq_t         blt_in   [2];
  logic        cpu_ack_v[2];
  logic        blt_ack_v[2];
  logic [15:0] rdata_v  [2];
  logic        vram_we_v[2];
  logic        vram_re_v[2];
  logic [13:0] vram_addr_v[2];
  logic [15:0] vram_din_v[2];
  logic        vram_ub_v[2];
  logic        vram_lb_v[2];
  logic [15:0] vram_dout_v[2];
  logic [15:0] mem [2][1024];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vram_arbiter #(.FIXED_CPU_PRIO(1'b0)) u_dut_rr (
    .clk(clk), .resetn(resetn_v[0]),
    .cpu_req(cpu_in[0].req), .cpu_we(cpu_in[0].we), .cpu_addr(cpu_in[0].addr),
    .cpu_wdata(cpu_in[0].wdata), .cpu_ub(cpu_in[0].ub), .cpu_lb(cpu_in[0].lb),
    .cpu_ack(cpu_ack_v[0]),
    .blt_req(blt_in[0].req), .blt_we(blt_in[0].we), .blt_addr(blt_in[0].addr),
    .blt_wdata(blt_in[0].wdata), .blt_ub(blt_in[0].ub), .blt_lb(blt_in[0].lb),
    .blt_ack(blt_ack_v[0]), .rdata(rdata_v[0]),
    .vram_we(vram_we_v[0]), .vram_re(vram_re_v[0]), .vram_addr(vram_addr_v[0]),
    .vram_din(vram_din_v[0]), .vram_ub(vram_ub_v[0]), .vram_lb(vram_lb_v[0]),
    .vram_dout(vram_dout_v[0])
  );

  vram_arbiter #(.FIXED_CPU_PRIO(1'b1)) u_dut_fx (
    .clk(clk), .resetn(resetn_v[1]),
    .cpu_req(cpu_in[1].req), .cpu_we(cpu_in[1].we), .cpu_addr(cpu_in[1].addr),
    .cpu_wdata(cpu_in[1].wdata), .cpu_ub(cpu_in[1].ub), .cpu_lb(cpu_in[1].lb),
    .cpu_ack(cpu_ack_v[1]),
    .blt_req(blt_in[1].req), .blt_we(blt_in[1].we), .blt_addr(blt_in[1].addr),
    .blt_wdata(blt_in[1].wdata), .blt_ub(blt_in[1].ub), .blt_lb(blt_in[1].lb),
    .blt_ack(blt_ack_v[1]), .rdata(rdata_v[1]),
    .vram_we(vram_we_v[1]), .vram_re(vram_re_v[1]), .vram_addr(vram_addr_v[1]),
    .vram_din(vram_din_v[1]), .vram_ub(vram_ub_v[1]), .vram_lb(vram_lb_v[1]),
    .vram_dout(vram_dout_v[1])
  );

  // VRAM models: byte-enabled write, read data one cycle after vram_re.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (vram_we_v[d]) begin
        if (vram_ub_v[d]) mem[d][vram_addr_v[d][9:0]][15:8] <= vram_din_v[d][15:8];
        if (vram_lb_v[d]) mem[d][vram_addr_v[d][9:0]][7:0]  <= vram_din_v[d][7:0];
      end
      if (vram_re_v[d]) vram_dout_v[d] <= mem[d][vram_addr_v[d][9:0]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Waits (bounded) for either ack on instance d; who=0 cpu, 1 blt.
  task automatic wait_ack(input int d, output int who, output int at);
    bit got = 1'b0;
    who = 2;
    at  = 0;
    for (int n = 0; n < 12 && !got; n++) begin
      @(negedge clk);
      if (cpu_ack_v[d] || blt_ack_v[d]) begin
        got = 1'b1;
        who = blt_ack_v[d] ? 1 : 0;
        at  = cyc;
      end
    end
    chk("ack_seen", 32'(got), 32'd1);
  endtask

  // One cycle-exact transaction from an idle arbiter; called at a negedge.
  task automatic txn(input int d, input bit blt, input bit we, input logic [13:0] addr,
                     input logic [15:0] wd, input bit ub, input bit lb,
                     input logic [15:0] exp_rd, input string tag);
    rq_t r;
    r = '{1'b1, we, addr, wd, ub, lb};
    if (blt) blt_in[d] = r; else cpu_in[d] = r;
    @(posedge clk);                       // edge N: request sampled
    @(negedge clk);                       // cycle N+1
    chk({tag, "_we"},   32'(vram_we_v[d]), 32'(we));
    chk({tag, "_re"},   32'(vram_re_v[d]), 32'(!we));
    chk({tag, "_addr"}, 32'(vram_addr_v[d]), 32'(addr));
    if (we) chk({tag, "_din"}, 32'({vram_din_v[d], vram_ub_v[d], vram_lb_v[d]}), 32'({wd, ub, lb}));
    @(negedge clk);                       // cycle N+2
    chk({tag, "_cap"}, 32'({vram_we_v[d], vram_re_v[d], cpu_ack_v[d], blt_ack_v[d]}), 32'd0);
    @(negedge clk);                       // cycle N+3
    chk({tag, "_ack"}, 32'({cpu_ack_v[d], blt_ack_v[d]}), blt ? 32'b01 : 32'b10);
    if (!we) chk({tag, "_rdata"}, 32'(rdata_v[d]), 32'(exp_rd));
    @(posedge clk); #1;
    if (blt) blt_in[d].req = 1'b0; else cpu_in[d].req = 1'b0;
    @(negedge clk);
    chk({tag, "_ackoff"}, 32'({cpu_ack_v[d], blt_ack_v[d]}), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int who, at, prev;
    for (int d = 0; d < 2; d++) begin
      resetn_v[d] = 1'b0;
      cpu_in[d]   = '0;
      blt_in[d]   = '0;
      vram_dout_v[d] = 16'h0;
      for (int i = 0; i < 1024; i++) mem[d][i] = 16'h0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_strb", 32'({vram_we_v[0], vram_re_v[0], cpu_ack_v[0], blt_ack_v[0],
                         vram_we_v[1], vram_re_v[1], cpu_ack_v[1], blt_ack_v[1]}), 32'd0);
    @(posedge clk); #1;
    resetn_v[0] = 1'b1;
    resetn_v[1] = 1'b1;

    // Idle after reset: nothing moves.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_strb", 32'({vram_we_v[0], vram_re_v[0], cpu_ack_v[0], blt_ack_v[0],
                            vram_we_v[1], vram_re_v[1], cpu_ack_v[1], blt_ack_v[1]}), 32'd0);
    end
    chk("idle_addr",  32'({vram_addr_v[0], vram_addr_v[1]}), 32'd0);
    chk("idle_din",   32'({vram_din_v[0], vram_din_v[1]}), 32'd0);
    chk("idle_rdata", 32'({rdata_v[0], rdata_v[1]}), 32'd0);
    chk("idle_be",    32'({vram_ub_v[0], vram_lb_v[0], vram_ub_v[1], vram_lb_v[1]}), 32'd0);

    // Round-robin, both held: CPU, BLT, CPU, BLT, 4 cycles apart.
    cpu_in[0] = '{1'b1, 1'b1, 14'h0010, 16'h1111, 1'b1, 1'b1};
    blt_in[0] = '{1'b1, 1'b1, 14'h0020, 16'h2222, 1'b1, 1'b1};
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_ack(0, who, at);
      chk("rr_order", 32'(who), 32'(k % 2));
      if (k > 0) chk("rr_gap", 32'(at - prev), 32'd4);
      prev = at;
    end
    @(posedge clk); #1;
    cpu_in[0].req = 1'b0;
    blt_in[0].req = 1'b0;
    @(negedge clk);

    // CPU writes/reads with byte enables.
    txn(0, 1'b0, 1'b1, 14'h0100, 16'h1234, 1'b1, 1'b1, 16'h0000, "cpu_wr");
    txn(0, 1'b0, 1'b0, 14'h0100, 16'h0000, 1'b1, 1'b1, 16'h1234, "cpu_rd");
    repeat (3) @(negedge clk);
    chk("addr_hold", 32'(vram_addr_v[0]), 32'h0100);
    txn(0, 1'b0, 1'b1, 14'h0100, 16'hAB55, 1'b0, 1'b1, 16'h0000, "cpu_wr_lb");
    txn(0, 1'b0, 1'b0, 14'h0100, 16'h0000, 1'b0, 1'b0, 16'h1255, "cpu_rd_lb");
    txn(0, 1'b0, 1'b1, 14'h0100, 16'hFFFF, 1'b0, 1'b0, 16'h0000, "cpu_wr_nobe");
    txn(0, 1'b0, 1'b0, 14'h0100, 16'h0000, 1'b1, 1'b1, 16'h1255, "cpu_rd_nobe");
    txn(0, 1'b0, 1'b0, 14'h0020, 16'h0000, 1'b1, 1'b1, 16'h2222, "cpu_rd_blt");
    txn(0, 1'b1, 1'b0, 14'h0010, 16'h0000, 1'b1, 1'b1, 16'h1111, "blt_rd_cpu");

    // Reset during a blitter write's ISSUE cycle.
    blt_in[0] = '{1'b1, 1'b1, 14'h0300, 16'h7777, 1'b1, 1'b1};
    @(posedge clk);
    @(negedge clk);
    chk("abort_pre_we", 32'(vram_we_v[0]), 32'd1);
    #1 resetn_v[0] = 1'b0;
    #1;
    chk("abort_strb", 32'({vram_we_v[0], vram_re_v[0], cpu_ack_v[0], blt_ack_v[0]}), 32'd0);
    chk("abort_addr", 32'(vram_addr_v[0]), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_noack", 32'(blt_ack_v[0]), 32'd0);
    end
    @(posedge clk); #1;
    resetn_v[0] = 1'b1;
    cpu_in[0] = '{1'b1, 1'b0, 14'h0300, 16'h0000, 1'b1, 1'b1};
    wait_ack(0, who, at);
    chk("post_rst_first", 32'(who), 32'd0);
    chk("post_rst_nowr", 32'(rdata_v[0]), 32'h0000);
    @(posedge clk); #1;
    cpu_in[0].req = 1'b0;
    wait_ack(0, who, at);
    chk("post_rst_blt", 32'(who), 32'd1);
    @(posedge clk); #1;
    blt_in[0].req = 1'b0;
    @(negedge clk);

    // Fixed CPU priority: CPU starves the blitter while it keeps requesting.
    cpu_in[1] = '{1'b1, 1'b1, 14'h0040, 16'h4444, 1'b1, 1'b1};
    blt_in[1] = '{1'b1, 1'b1, 14'h0050, 16'h5555, 1'b1, 1'b1};
    prev = 0;
    for (int k = 0; k < 3; k++) begin
      wait_ack(1, who, at);
      chk("fx_cpu", 32'(who), 32'd0);
      if (k > 0) chk("fx_gap", 32'(at - prev), 32'd4);
      prev = at;
    end
    @(posedge clk); #1;
    cpu_in[1].req = 1'b0;
    wait_ack(1, who, at);
    chk("fx_blt", 32'(who), 32'd1);
    chk("fx_blt_gap", 32'(at - prev), 32'd4);
    @(posedge clk); #1;
    blt_in[1].req = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
